// File: rtl/hd_pkg.sv
// hd_pkg: shared state type, tile geometry helpers and index widths for the HD tile scheduler
package hd_pkg;
  typedef enum logic [2:0] {S_IDLE, S_STREAM, S_WAIT_MAC, S_CLEAR, S_DONE} sched_state_t;
  function automatic int col_tiles(int div_size, int n_size);
    return (div_size + n_size - 1) / n_size;
  endfunction
  function automatic int row_groups(int dhv_size, int m_size);
    return (dhv_size + m_size - 1) / m_size;
  endfunction
  function automatic int last_lanes(int div_size, int n_size);
    return div_size - (col_tiles(div_size, n_size) - 1) * n_size;
  endfunction
  function automatic int idx_w(int limit);
    return $clog2(limit) + 1;
  endfunction
endpackage

// File: rtl/hd_tile_slicer.sv
// hd_tile_slicer: combinational tile extraction (wrapped projection bits, feature lanes, lane mask)
module hd_tile_slicer #(
  parameter int DHV_SIZE = 4000,
  parameter int DIV_SIZE = 512,
  parameter int N_SIZE   = 16,
  parameter int M_SIZE   = 16,
  parameter int FTWIDTH  = 8,
  parameter int XW       = 10,
  parameter int YW       = 13
) (
  input  logic [XW-1:0]               i_x,
  input  logic [YW-1:0]               i_y,
  input  logic [DHV_SIZE-1:0]         i_proj,
  input  logic [DIV_SIZE*FTWIDTH-1:0] i_feat,
  output logic [N_SIZE+M_SIZE-1:0]    o_proj,
  output logic [N_SIZE*FTWIDTH-1:0]   o_feat,
  output logic [N_SIZE-1:0]           o_mask
);
  localparam int PW = $clog2(DHV_SIZE);
  localparam int FW = $clog2(DIV_SIZE);
  logic [FTWIDTH-1:0] w_lane [DIV_SIZE];
  for (genvar g = 0; g < DIV_SIZE; g++) begin : g_lane
    assign w_lane[g] = i_feat[g*FTWIDTH +: FTWIDTH];
  end
  always_comb begin
    o_proj = '0;
    o_feat = '0;
    o_mask = '0;
    for (int i = 0; i < N_SIZE + M_SIZE; i++)
      o_proj[i] = i_proj[PW'((int'(i_x) + int'(i_y) + i) % DHV_SIZE)];
    for (int j = 0; j < N_SIZE; j++) begin
      o_mask[j] = int'(i_x) + j < DIV_SIZE;
      o_feat[j*FTWIDTH +: FTWIDTH] = o_mask[j] ? w_lane[FW'(int'(i_x) + j)] : '0;
    end
  end
endmodule

// File: rtl/hd_tile_scheduler.sv
// hd_tile_scheduler: streams projection/feature tiles to a MAC array and sequences row-group clears.
// Optional stall_cycles counter enabled by defining HD_SCHED_PERF_EN.
module hd_tile_scheduler import hd_pkg::*; #(
  parameter int DHV_SIZE = 4000,
  parameter int DIV_SIZE = 512,
  parameter int N_SIZE   = 16,
  parameter int M_SIZE   = 16,
  parameter int FTWIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        reset_in,
  input  logic                        start,
  input  logic [DHV_SIZE-1:0]         projections,
  input  logic [DIV_SIZE*FTWIDTH-1:0] features,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N_SIZE+M_SIZE-1:0]    out_projections,
  output logic [N_SIZE*FTWIDTH-1:0]   out_features,
  output logic [N_SIZE-1:0]           out_lane_mask,
  output logic                        out_last,
  input  logic                        mac_done,
  output logic                        out_reset,
  output logic                        out_done,
`ifdef HD_SCHED_PERF_EN
  output logic [31:0]                 stall_cycles,
`endif
  output logic                        busy
);
  localparam int XW = idx_w(DIV_SIZE);
  localparam int YW = idx_w(DHV_SIZE);
  localparam logic [XW-1:0] LAST_X = XW'((col_tiles(DIV_SIZE, N_SIZE) - 1) * N_SIZE);
  localparam logic [YW-1:0] LAST_Y = YW'((row_groups(DHV_SIZE, M_SIZE) - 1) * M_SIZE);
  sched_state_t r_state;
  logic [XW-1:0] r_x, w_nx;
  logic [YW-1:0] r_y, w_ny;
  logic w_go, w_adv, w_row, w_load;
  logic [N_SIZE+M_SIZE-1:0]  w_proj;
  logic [N_SIZE*FTWIDTH-1:0] w_feat;
  logic [N_SIZE-1:0]         w_mask;
  // Slicer looks at the coordinates of the tile about to be loaded, so accepts need no bubble
  assign w_go   = (r_state == S_IDLE || r_state == S_DONE) && start;
  assign w_adv  = r_state == S_STREAM && out_valid && out_ready && !out_last;
  assign w_row  = r_state == S_CLEAR && r_y != LAST_Y;
  assign w_load = w_go || w_adv || w_row;
  assign w_nx   = w_adv ? r_x + XW'(N_SIZE) : '0;
  assign w_ny   = w_row ? r_y + YW'(M_SIZE) : (w_go ? '0 : r_y);
  hd_tile_slicer #(
    .DHV_SIZE(DHV_SIZE), .DIV_SIZE(DIV_SIZE), .N_SIZE(N_SIZE), .M_SIZE(M_SIZE),
    .FTWIDTH(FTWIDTH), .XW(XW), .YW(YW)
  ) u_slicer (
    .i_x(w_nx), .i_y(w_ny), .i_proj(projections), .i_feat(features),
    .o_proj(w_proj), .o_feat(w_feat), .o_mask(w_mask)
  );
  always_ff @(posedge clk) begin
    if (reset_in) begin
      r_state         <= S_IDLE;
      r_x             <= '0;
      r_y             <= '0;
      out_valid       <= 1'b0;
      out_projections <= '0;
      out_features    <= '0;
      out_lane_mask   <= '0;
      out_last        <= 1'b0;
      out_reset       <= 1'b0;
      out_done        <= 1'b0;
      busy            <= 1'b0;
    end else begin
      out_reset <= 1'b0;
      if (w_load) begin
        r_x             <= w_nx;
        r_y             <= w_ny;
        out_projections <= w_proj;
        out_features    <= w_feat;
        out_lane_mask   <= w_mask;
        out_last        <= w_nx == LAST_X;
        out_valid       <= 1'b1;
      end
      case (r_state)
        S_IDLE, S_DONE: if (start) begin
          r_state  <= S_STREAM;
          out_done <= 1'b0;
          busy     <= 1'b1;
        end
        S_STREAM: if (out_valid && out_ready && out_last) begin
          r_state   <= S_WAIT_MAC;
          out_valid <= 1'b0;
        end
        S_WAIT_MAC: if (mac_done) begin
          r_state   <= S_CLEAR;
          out_reset <= 1'b1;
        end
        S_CLEAR: begin
          r_state  <= r_y == LAST_Y ? S_DONE : S_STREAM;
          out_done <= r_y == LAST_Y;
          busy     <= r_y != LAST_Y;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`ifdef HD_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (reset_in || w_go)
      stall_cycles <= '0;
    else if (((out_valid && !out_ready) || r_state == S_WAIT_MAC) && !(&stall_cycles))
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif
endmodule

// File: doc/hd_tile_scheduler.md
Name: hd_tile_scheduler

Overview:
- Parametrised successor to the single-MAC HD encoder controller.
- Walks the projection bit-vector and the input feature vector in tiles of N_SIZE features by M_SIZE hypervector rows. Presents each tile to a downstream MAC array over a valid/ready handshake.
- Sequences per-row-group accumulate/clear with the MAC and flags completion of the whole hypervector.
- Adds start control, back-pressure, ragged last tiles and index wrap-around.

Parameters:
- DHV_SIZE, 4000, hypervector dimension (projection bits).
- DIV_SIZE, 512, input feature count.
- N_SIZE, 16, features per tile (MAC lanes).
- M_SIZE, 16, hypervector rows per row group.
- FTWIDTH, 8, bits per feature.

Ports:
- clk  in  1  clock.
- reset_in  in  1  synchronous active-high reset.
- start  in  1  begin encoding pass; sampled only in IDLE or DONE.
- projections  in  DHV_SIZE  projection bit-vector; held stable during a pass.
- features  in  DIV_SIZE*FTWIDTH  packed feature vector; held stable during a pass.
- out_valid  out  1  tile on outputs is valid.
- out_ready  in  1  MAC accepts tile.
- out_projections  out  N_SIZE+M_SIZE  projection bit slice for the tile.
- out_features  out  N_SIZE*FTWIDTH  feature slice; unused lanes are zero.
- out_lane_mask  out  N_SIZE  1 per lane carrying a real feature.
- out_last  out  1  tile is the last of its row group.
- mac_done  in  1  MAC finished accumulating the current row group.
- out_reset  out  1  one-cycle clear pulse to the MAC.
- out_done  out  1  pass complete; sticky.
- busy  out  1  state is neither IDLE nor DONE.

Behaviour:
- Constants:
  - COL_TILES = ceil(DIV_SIZE/N_SIZE).
  - ROW_GROUPS = ceil(DHV_SIZE/M_SIZE).
  - LAST_LANES = DIV_SIZE - (COL_TILES-1)*N_SIZE.
- Counters: cur_x steps 0..(COL_TILES-1)*N_SIZE by N_SIZE; cur_y steps 0..(ROW_GROUPS-1)*M_SIZE by M_SIZE. Both are sized by $clog2 of the respective limit plus 1.
- Reset: all outputs are 0, state is IDLE, counters are 0.
- States: IDLE, STREAM, WAIT_MAC, CLEAR, DONE.
- IDLE/DONE:
  - start=1 clears counters and out_done, then goes to STREAM next cycle.
  - start=0 holds the state.
- STREAM:
  - out_valid=1 with registered tile outputs for (cur_x, cur_y).
  - out_projections[i] = projections[(cur_x+cur_y+i) mod DHV_SIZE], for i < N_SIZE+M_SIZE. The index wraps at the end of the vector.
  - out_features lane j = features[cur_x+j] when cur_x+j < DIV_SIZE, else 0. out_lane_mask[j] matches.
  - out_last = (cur_x == last column).
  - On out_valid && out_ready:
    - not last: advance cur_x and load the next tile with no bubble, so one tile is accepted per cycle under constant ready.
    - last: go to WAIT_MAC and deassert out_valid.
  - While out_ready=0, all tile outputs hold stable.
- WAIT_MAC: waits for mac_done=1, then goes to CLEAR. mac_done outside WAIT_MAC is ignored.
- CLEAR:
  - out_reset=1 for exactly one cycle.
  - last row group: go to DONE and set out_done=1.
  - otherwise: cur_x=0, cur_y += M_SIZE, go to STREAM.
- Ragged last row group (DHV_SIZE not a multiple of M_SIZE): handled by the wrap rule. No extra masking is applied to projection bits.
- reset_in mid-pass aborts immediately to the reset values. No out_reset pulse is issued.
- start while busy is ignored.

Optional Feature:
- Macro: HD_SCHED_PERF_EN.
- When defined, adds output stall_cycles [31:0]. It counts cycles with out_valid && !out_ready plus cycles in WAIT_MAC. It clears on reset_in or an accepted start and saturates at all-ones.
- When undefined, the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package hd_pkg:
  - sched_state_t enum.
  - Functions for COL_TILES, ROW_GROUPS and LAST_LANES.
  - Index widths.
- Sub-module hd_tile_slicer: combinational extraction of projection bits with modulo wrap, feature lanes and lane mask from (cur_x, cur_y). The top module registers its outputs.

Test Plan (params DHV_SIZE=40, DIV_SIZE=20, N_SIZE=8, M_SIZE=8, FTWIDTH=8; features[i]=i; projections[k]=k[0]):
- Constant ready, mac_done 2 cycles after out_last:
  - 3 tiles per group, masks 0xFF, 0xFF, 0x0F.
  - Third tile lanes 4-7 are 0.
  - 5 groups, 5 out_reset pulses, then out_done=1.
- out_ready toggling 1,0,0,1 mid-row: outputs stable while not ready; no tile skipped or repeated (cur_x sequence 0, 8, 16).
- Group cur_y=32, tile cur_x=16: projection indices 48..63 wrap to 8..23. Check out_projections bit pattern alternating starting at 0.
- reset_in asserted during WAIT_MAC of group 2: next cycle all outputs 0 and state IDLE. New start restarts at cur_y=0.
- start held during STREAM and mac_done pulsed during STREAM: no effect. After DONE, start=1 clears out_done and reruns the pass.
- HD_SCHED_PERF_EN defined: 3 not-ready cycles plus 2 WAIT_MAC cycles in group 0 gives stall_cycles=5 at the end of group 0.
